// File: rtl/simple_imem_responder.sv
// simple_imem_responder
//   Memory-side responder for the core's instruction-fetch read port.
//   After reset a byte stream is packed little-endian into 32-bit words and
//   written sequentially into a local array (LOAD).  Once the image is
//   complete (last byte or array full) the block serves one-cycle-latency
//   word reads from that array (RUN).  RUN is left only through reset.
//
// Ports
//   clk_i       clock, rising edge
//   rstn_i      asynchronous active-low reset
//   read_i      fetch read strobe
//   raddr_i     fetch byte address, sampled when read_i=1
//   rdata_o     registered read data, valid the cycle after the read
//   ld_valid_i  load byte valid
//   ld_data_i   load byte
//   ld_last_i   final byte of the image, qualified by ld_valid_i
//   ld_ready_o  load byte accepted when high (LOAD only)
//   busy_o      load phase active, holds the core
//   err_o       sticky: misaligned or out-of-range read seen in RUN
module simple_imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        read_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_data_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t      state_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] wptr_q;
  logic [1:0]    cnt_q;
  logic [31:0]   asm_q;

  // Load-side datapath
  logic        accept;
  logic        word_done;
  logic        load_end;
  logic [31:0] asm_next;

  // Read-side decode
  logic [31:0]   off;
  logic          in_range;
  logic          aligned;
  logic          rd_ok;
  logic [AW-1:0] ridx;

  always_comb begin
    accept    = ld_valid_i & ld_ready_o;
    // Lanes above the current byte are still zero because the assembly
    // register clears after each word write, so OR-ing in the new byte
    // also yields zero-filled upper lanes for a partial last word.
    asm_next  = asm_q | ({24'h00_0000, ld_data_i} << {cnt_q, 3'b000});
    word_done = accept & ((cnt_q == 2'd3) | ld_last_i);
    load_end  = word_done & (ld_last_i | (wptr_q == LAST_IDX));
  end

  always_comb begin
    off      = raddr_i - BASE_ADDR;
    // Offset below 4*DEPTH_WORDS is equivalent to the upper offset bits
    // being zero; the explicit lower-bound compare stops addresses below
    // the base from wrapping into the window.
    in_range = (raddr_i >= BASE_ADDR) && (off[31:AW+2] == '0);
    aligned  = (off[1:0] == 2'b00);
    rd_ok    = in_range & aligned;
    ridx     = off[AW+1:2];
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (word_done) begin
      mem[wptr_q] <= asm_next;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_LOAD;
      busy_o     <= 1'b1;
      ld_ready_o <= 1'b1;
      err_o      <= 1'b0;
      rdata_o    <= NOP_INSTR;
      wptr_q     <= '0;
      cnt_q      <= '0;
      asm_q      <= '0;
    end else begin
      if (accept) begin
        if (word_done) begin
          wptr_q <= wptr_q + 1'b1;
          cnt_q  <= '0;
          asm_q  <= '0;
        end else begin
          cnt_q  <= cnt_q + 2'd1;
          asm_q  <= asm_next;
        end
      end

      if (load_end) begin
        state_q    <= ST_RUN;
        busy_o     <= 1'b0;
        ld_ready_o <= 1'b0;
      end

      if (read_i) begin
        if (state_q == ST_LOAD) begin
          rdata_o <= NOP_INSTR;
        end else if (rd_ok) begin
          rdata_o <= mem[ridx];
        end else begin
          rdata_o <= NOP_INSTR;
          err_o   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/simple_imem_responder.md
# simple_imem_responder

Memory-side responder for the core's simple instruction-fetch read port. It serves one-cycle-latency word reads from a local word array mapped at a fixed base address. After reset it first runs a boot-load phase: a byte stream is packed little-endian into words and written sequentially into the array. During that phase the core is held off through `busy_o`.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: array depth in 32-bit words. Must be a power of two, ≥ 2.
- `BASE_ADDR`, default 32'h8000_0000: byte address of word 0. Must be aligned to 4·`DEPTH_WORDS`.
- `NOP_INSTR`, default 32'h0000_0013: word returned for invalid or disallowed reads.

Ports (clock and reset first):
- `clk_i`  in  1  clock. One clock domain; all logic on its rising edge.
- `rstn_i`  in  1  reset, asynchronous and active-low.
- `read_i`  in  1  fetch read strobe.
- `raddr_i`  in  32  fetch byte address. Sampled when `read_i`=1.
- `rdata_o`  out  32  read data, registered. Valid the cycle after the read.
- `ld_valid_i`  in  1  load byte valid.
- `ld_data_i`  in  8  load byte.
- `ld_last_i`  in  1  final byte of the image. Qualified by `ld_valid_i`.
- `ld_ready_o`  out  1  responder accepts a load byte.
- `busy_o`  out  1  load phase active. Drives the core stall/hold.
- `err_o`  out  1  sticky flag: a misaligned or out-of-range read occurred in RUN.

## Operation
- States: LOAD and RUN. Reset enters LOAD. There is no path from RUN back to LOAD except reset.
- Byte transfer: a byte is accepted when `ld_valid_i` & `ld_ready_o`. In LOAD, `ld_ready_o`=1; in RUN, `ld_ready_o`=0.
- Packing: a 2-bit byte counter selects the lane. The first accepted byte of a word goes to [7:0], the second to [15:8], and so on.
- Word write: on the 4th byte, the assembled word is written to `mem[wptr]` on that same edge. Then `wptr` increments, the counter clears and the assembly register clears.
- `ld_last_i` accepted with a byte: the partial word is written at `wptr`, with unfilled upper lanes zero. The state then goes to RUN. If the last byte completes a word, that is a normal 4-byte write, then RUN.
- Full array: the write to word `DEPTH_WORDS`-1 forces RUN even without `ld_last_i`. Later stream bytes are not accepted.
- Read address decode: index = (`raddr_i` − `BASE_ADDR`)[log2(DEPTH)+1:2]. A read is in range when `BASE_ADDR` ≤ `raddr_i` < `BASE_ADDR` + 4·`DEPTH_WORDS`. Unsigned compare; no wrap-around aliasing.
- RUN with `read_i`=1, in range and aligned: `rdata_o` ← `mem[index]`.
- RUN with `read_i`=1 and either out of range or `raddr_i`[1:0]≠0: `rdata_o` ← `NOP_INSTR`, and `err_o` is set.
- LOAD with `read_i`=1: `rdata_o` ← `NOP_INSTR`, and `err_o` is unchanged.
- `read_i`=0: `rdata_o` holds its value. The responder has no stall or ready output; the fetch side relies on fixed latency.
- Array contents are not reset. Words never written read back undefined.

## Timing
- Reset values: `rdata_o`=`NOP_INSTR`, `busy_o`=1, `ld_ready_o`=1, `err_o`=0. Internally `wptr`=0, byte counter=0, assembly register=0.
- Read latency: exactly 1 cycle. The address is presented at edge N and the data is visible after edge N+1. Back-to-back reads give one word per cycle.
- `busy_o` and `ld_ready_o` are registered. Both fall in the cycle after the edge that accepted the last byte (or the final full-array word). That edge also performs the word write.
- First valid fetch: the first read accepted with `busy_o`=0 returns array data.
- Load throughput: 1 byte per cycle. Gaps in `ld_valid_i` are allowed, and the byte counter holds across them.
- Simultaneous read and write during LOAD: the read returns `NOP_INSTR`, so there is no read/write hazard.
- Reset asserted mid-load: all state returns to reset values immediately, and a new load starts at word 0, lane 0. Already written words keep their values but are overwritten by the new load.
- `err_o` stays set until reset.

## Test plan
- Load bytes 13 00 00 00 93 00 10 00, with `ld_last_i` on the 8th byte. Expect `busy_o`=0 one cycle later. Read 0x8000_0000 then 0x8000_0004 back-to-back; expect 0x0000_0013 then 0x0010_0093 on consecutive cycles.
- Load 6 bytes AA BB CC DD EE FF, with last on FF. Expect word1=0x0000_FFEE, word0=0xDDCC_BBAA, and RUN entered.
- In RUN, read 0x7FFF_FFFC, then 0x8000_0002, then 0x8000_0000 + 4·`DEPTH_WORDS`. Expect `NOP_INSTR` each time, `err_o`=1 after the first, and `err_o` still 1 after further valid reads.
- Drive `read_i`=1 during LOAD; expect `NOP_INSTR` and `err_o`=0. In RUN, drop `read_i` for 3 cycles; expect `rdata_o` stable.
- Stream exactly 4·`DEPTH_WORDS` bytes without last. Expect RUN after the final byte, `ld_ready_o`=0, and further bytes ignored. The last word reads back correctly.
- Assert reset after 5 bytes, then reload 4 bytes 01 02 03 04 with last. Expect word0=0x0403_0201.
